// File: rtl/counter.sv
// Prescaled modulo counter: advances num by STEP once every DIV clocks and
// wraps past the terminal count MAX back into the 0..MAX range.
module counter #(
  parameter int unsigned      WIDTH = 16,
  parameter int unsigned      DIV   = 1,
  parameter logic [WIDTH-1:0] STEP  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,  // active-high synchronous reset
  output logic [WIDTH-1:0] num
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic             advance_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] num_d;
  logic [WIDTH-1:0] num_q;

  generate
    if (DIV == 1) begin : g_nodiv
      // Without prescaling every clock is an advance.
      assign advance_s = 1'b1;
    end else begin : g_div
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

      logic [DIV_W-1:0] div_cnt_d;
      logic [DIV_W-1:0] div_cnt_q;

      // Prescaler next state: count 0..DIV-1 then wrap to 0.
      always_comb begin
        div_cnt_d = div_cnt_q;
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = {DIV_W{1'b0}};
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      // Prescaler register with synchronous reset.
      always_ff @(posedge clk) begin
        if (reset_n) begin
          div_cnt_q <= {DIV_W{1'b0}};
        end else begin
          div_cnt_q <= div_cnt_d;
        end
      end

      assign advance_s = (div_cnt_q == DIV_LAST);
    end
  endgenerate

  // Count next state: the sum is formed one bit wider so a carry out of
  // WIDTH bits still compares as larger than MAX before wrapping.
  always_comb begin
    num_d = num_q;
    sum_s = {1'b0, num_q} + {1'b0, STEP};
    if (advance_s) begin
      if (sum_s > {1'b0, MAX}) begin
        // Result is below STEP, so it fits in WIDTH bits; mod-2^WIDTH math is exact.
        num_d = sum_s[WIDTH-1:0] - MAX - WIDTH'(1);
      end else begin
        num_d = sum_s[WIDTH-1:0];
      end
    end else begin
      num_d = num_q;
    end
  end

  // Count register; reset takes priority over any advance on the same edge.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      num_q <= {WIDTH{1'b0}};
    end else begin
      num_q <= num_d;
    end
  end

  assign num = num_q;

endmodule

// File: tb/tb_counter.sv
// Bench for counter: four parameterisations share clock and reset; a model
// based on edges-since-reset predicts every output on every cycle.
module tb_counter;

  logic        clk;
  logic        reset_n;
  logic [15:0] num_def;
  logic [15:0] num_d4;
  logic [7:0]  num_w8;
  logic [3:0]  num_w4;

  int    vectors;
  int    miscompares;
  longint k_m;       // edges since the last sampled reset edge
  bit    valid_m;    // a reset edge has been seen

  int d4_seq [8] = '{0, 0, 0, 1, 1, 1, 1, 2};
  int w8_seq [8] = '{3, 6, 9, 2, 5, 8, 1, 4};

  counter u_def (.clk(clk), .reset_n(reset_n), .num(num_def));
  counter #(.WIDTH(16), .DIV(4)) u_d4 (.clk(clk), .reset_n(reset_n), .num(num_d4));
  counter #(.WIDTH(8), .DIV(1), .STEP(8'd3), .MAX(8'd9))
    u_w8 (.clk(clk), .reset_n(reset_n), .num(num_w8));
  counter #(.WIDTH(4), .DIV(3), .STEP(4'd7), .MAX(4'd12))
    u_w4 (.clk(clk), .reset_n(reset_n), .num(num_w4));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advances happen floor(k/DIV) times; each adds STEP modulo MAX+1.
  function automatic logic [31:0] expv(input longint k, input longint div,
                                       input longint step, input longint maxv);
    return 32'(((k / div) * step) % (maxv + 1));
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k_m);
    end
  endtask

  // One clock: drive reset, optionally glitch it between edges, update the
  // model at the edge, then compare every instance on the falling edge.
  task automatic tick(input bit rst, input bit glitch);
    reset_n = rst;
    if (glitch) begin
      #3;
      reset_n = 1'b1;
      #3;
      reset_n = 1'b0;
    end
    @(posedge clk);
    if (reset_n) begin
      k_m = 0;
      valid_m = 1'b1;
    end else if (valid_m) begin
      k_m++;
    end
    @(negedge clk);
    if (valid_m) begin
      cmp("def", 32'(num_def), expv(k_m, 1, 1, 65535));
      cmp("d4",  32'(num_d4),  expv(k_m, 4, 1, 65535));
      cmp("w8",  32'(num_w8),  expv(k_m, 1, 3, 9));
      cmp("w4",  32'(num_w4),  expv(k_m, 3, 7, 12));
    end
  endtask

  initial begin
    int guard;
    logic [31:0] prev;
    vectors = 0;
    miscompares = 0;
    k_m = 0;
    valid_m = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // Reset held for five edges keeps everything at zero.
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      cmp("reset_def", 32'(num_def), 32'd0);
      cmp("reset_d4",  32'(num_d4),  32'd0);
    end

    // First edges after release: literal sequences.
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0);
      cmp("seq_def", 32'(num_def), 32'(i + 1));
      cmp("seq_d4",  32'(num_d4),  32'(d4_seq[i]));
      cmp("seq_w8",  32'(num_w8),  32'(w8_seq[i]));
    end

    for (int i = 8; i < 400; i++) tick(1'b0, 1'b0);
    cmp("def_400", 32'(num_def), 32'd400);
    cmp("d4_400",  32'(num_d4),  32'd100);

    for (int i = 400; i < 65535; i++) tick(1'b0, 1'b0);
    cmp("def_max", 32'(num_def), 32'd65535);
    tick(1'b0, 1'b0);
    cmp("def_wrap0", 32'(num_def), 32'd0);
    tick(1'b0, 1'b0);
    cmp("def_wrap1", 32'(num_def), 32'd1);

    // Single-edge reset mid-count.
    tick(1'b1, 1'b0);
    cmp("rst1_def", 32'(num_def), 32'd0);
    tick(1'b0, 1'b0);
    cmp("rst1_next", 32'(num_def), 32'd1);

    // Prescaler at phase 2, then reset: a full four-edge period follows.
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      cmp("d4_restart_hold", 32'(num_d4), 32'd0);
    end
    tick(1'b0, 1'b0);
    cmp("d4_restart_adv", 32'(num_d4), 32'd1);

    // Walk w8 up to its terminal count, then reset on that advance edge.
    guard = 0;
    while (expv(k_m, 1, 3, 9) != 32'd9 && guard < 20) begin
      tick(1'b0, 1'b0);
      guard++;
    end
    cmp("w8_at_max", 32'(num_w8), 32'd9);
    tick(1'b1, 1'b0);
    cmp("w8_rst_at_max", 32'(num_w8), 32'd0);
    tick(1'b0, 1'b0);
    cmp("w8_after_rst", 32'(num_w8), 32'd3);

    // Reset pulses between edges are ignored.
    for (int i = 0; i < 4; i++) begin
      prev = 32'(num_def);
      tick(1'b0, 1'b1);
      cmp("glitch_def", 32'(num_def), prev + 32'd1);
    end

    // Randomised reset and glitch activity.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit g;
      r = ($urandom_range(0, 19) == 0);
      g = !r && ($urandom_range(0, 9) == 0);
      tick(r, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
- One clock; reset is synchronous and active-high.
- REQ-001: Parameter WIDTH, default 16, counter/output width in bits (legal 2..32).
- REQ-002: Parameter DIV, default 1, prescale ratio: counter advances once every DIV clocks (legal 1..65535).
- REQ-003: Parameter STEP, default 1, increment added per advance (legal 1..2^WIDTH-1).
- REQ-004: Parameter MAX, default 2^WIDTH-1, terminal count; legal STEP-1..2^WIDTH-1.
- REQ-005: clk, input, 1, sole clock; all state updates on rising edge.
- REQ-006: reset_n, input, 1, synchronous reset, active-high (1 = reset asserted) despite the _n suffix.
- REQ-007: num, output, WIDTH, current count, driven directly from a register.

Function
- REQ-008: Prescaler: internal counter div_cnt, width ceil(log2(DIV)) (min 1), counts 0..DIV-1 and wraps to 0; an advance pulse occurs on the clock where div_cnt == DIV-1.
- REQ-009: DIV = 1: advance pulse on every clock; prescaler logically absent.
- REQ-010: On an advance pulse with num + STEP <= MAX, num becomes num + STEP on that edge.
- REQ-011: On an advance pulse with num + STEP > MAX, num wraps to (num + STEP) - (MAX + 1); the sum is computed at WIDTH+1 bits, with no silent truncation before comparison.
- REQ-012: Default parameters: num counts 0,1,2,...,65535,0,... one step per clock (natural modulo-2^16 wrap).
- REQ-013: With no advance pulse, num holds its value.
- REQ-014: num is a registered output; no combinational path from reset_n to num.
- REQ-015: Latency: first increment visible on the first rising edge after the reset is sampled low when DIV = 1; after DIV edges otherwise.
- REQ-016: Reset asserted coincident with an advance pulse: reset wins; no increment occurs.
- REQ-017: No X propagation after the first reset edge; before any reset, contents are undefined (no initial-value reliance).

Reset
- REQ-018: reset_n sampled high at a rising edge sets num = 0 and div_cnt = 0 on that edge.
- REQ-019: Reset held for N edges keeps num = 0 for all N edges.
- REQ-020: Reset asserted mid-count (any num, any div_cnt) clears both on the next edge; counting restarts from 0 with a full DIV period before the first advance.
- REQ-021: Reset is not asynchronous: a reset_n pulse between clock edges that is low at every sampled edge has no effect.

Verification
- REQ-022: Default params, clk period 20 ns, reset_n=1 for 5 edges then 0 -> num=0 during reset; num=1,2,3... on successive edges; num=400 after 400 edges.
- REQ-023: Default params, run 65536 edges after reset release -> num reaches 65535, then 0 on the next edge, then 1.
- REQ-024: Default params, num=1234, assert reset_n for one edge -> num=0 on that edge; num=1 on the following edge.
- REQ-025: DIV=4, STEP=1 -> num increments on every 4th edge after reset release: 0,0,0,1,1,1,1,2; reset asserted when div_cnt=2 -> next advance occurs 4 edges after release.
- REQ-026: WIDTH=8, MAX=9, STEP=3 -> sequence 0,3,6,9,2,5,8,1 (wrap via REQ-011); num never exceeds 9.
- REQ-027: Reset asserted on an advance edge with num=MAX -> num=0 (not the wrap value), div_cnt=0.
